// File: rtl/rtc_bus_sequencer.sv
// Runs one single-byte read or write cycle on the RTC multiplexed AD bus per request.
// The address phase is always a write strobe. The data phase uses WR_n or RD_n depending on the latched operation.
module rtc_bus_sequencer #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 8,
  parameter int T_HD  = 2,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       win,
  input  logic       rin,
  input  logic [7:0] address,
  input  logic [7:0] datain,
  output logic       donew,
  output logic       doner,
  output logic [7:0] dataout,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic       ad_oe,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in
);

  localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(T_HD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SU, S_A_STB, S_A_HD, S_D_SU, S_D_STB, S_D_HD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       dataout_q, dataout_d;
  logic             donew_q, donew_d;
  logic             doner_q, doner_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             ad_sel_q, ad_sel_d;
  logic             ad_oe_q, ad_oe_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic             a_ph, d_ph;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      dataout_q <= '0;
      donew_q   <= 1'b0;
      doner_q   <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_sel_q  <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dataout_q <= dataout_d;
      donew_q   <= donew_d;
      doner_q   <= doner_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_sel_q  <= ad_sel_d;
      ad_oe_q   <= ad_oe_d;
      ad_out_q  <= ad_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    dataout_d = dataout_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (win || rin) begin
          state_d = S_A_SU;
          op_wr_d = win;
          addr_d  = address;
          data_d  = datain;
        end
      end
      S_A_SU:  if (cnt_q == SU_LAST) begin state_d = S_A_STB; cnt_d = '0; end
      S_A_STB: if (cnt_q == PW_LAST) begin state_d = S_A_HD;  cnt_d = '0; end
      S_A_HD:  if (cnt_q == HD_LAST) begin state_d = S_D_SU;  cnt_d = '0; end
      S_D_SU:  if (cnt_q == SU_LAST) begin state_d = S_D_STB; cnt_d = '0; end
      S_D_STB: begin
        if (cnt_q == PW_LAST) begin
          state_d = S_D_HD;
          cnt_d   = '0;
          if (!op_wr_q) dataout_d = ad_in;
        end
      end
      S_D_HD:  if (cnt_q == HD_LAST) begin state_d = S_DONE;  cnt_d = '0; end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pins are decoded from the next state so every output comes straight from a flop.
    a_ph     = (state_d == S_A_SU) || (state_d == S_A_STB) || (state_d == S_A_HD);
    d_ph     = (state_d == S_D_SU) || (state_d == S_D_STB) || (state_d == S_D_HD);
    busy_d   = (state_d != S_IDLE);
    cs_n_d   = !(a_ph || d_ph);
    wr_n_d   = !((state_d == S_A_STB) || ((state_d == S_D_STB) && op_wr_d));
    rd_n_d   = !((state_d == S_D_STB) && !op_wr_d);
    ad_sel_d = !a_ph;
    ad_oe_d  = a_ph || (d_ph && op_wr_d);
    donew_d  = (state_d == S_DONE) && op_wr_d;
    doner_d  = (state_d == S_DONE) && !op_wr_d;
    if (a_ph)
      ad_out_d = addr_d;
    else if (d_ph && op_wr_d)
      ad_out_d = data_d;
    else
      ad_out_d = ad_out_q;
  end

  assign donew   = donew_q;
  assign doner   = doner_q;
  assign dataout = dataout_q;
  assign busy    = busy_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad_sel  = ad_sel_q;
  assign ad_oe   = ad_oe_q;
  assign ad_out  = ad_out_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: a default-timing instance and a 1/1/1 timing instance.
// A shared monitor walks the bus pins of the selected instance.
module tb_rtc_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       win1, rin1, win2, rin2;
  logic [7:0] address, datain, rd_val;

  logic       donew1, doner1, busy1, cs_n1, rd_n1, wr_n1, ad_sel1, ad_oe1;
  logic [7:0] dataout1, ad_out1, ad_in1;
  logic       donew2, doner2, busy2, cs_n2, rd_n2, wr_n2, ad_sel2, ad_oe2;
  logic [7:0] dataout2, ad_out2, ad_in2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  // The RTC model only presents read data while its RD_n strobe is low.
  assign ad_in1 = rd_n1 ? 8'hEE : rd_val;
  assign ad_in2 = rd_n2 ? 8'hEE : rd_val;

  rtc_bus_sequencer dut1 (
    .clock(clock), .reset(reset), .win(win1), .rin(rin1),
    .address(address), .datain(datain), .donew(donew1), .doner(doner1),
    .dataout(dataout1), .busy(busy1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .ad_sel(ad_sel1), .ad_oe(ad_oe1), .ad_out(ad_out1), .ad_in(ad_in1)
  );

  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_HD(1), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .win(win2), .rin(rin2),
    .address(address), .datain(datain), .donew(donew2), .doner(doner2),
    .dataout(dataout2), .busy(busy2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2),
    .ad_sel(ad_sel2), .ad_oe(ad_oe2), .ad_out(ad_out2), .ad_in(ad_in2)
  );

  bit         sel = 1'b0;
  logic       m_donew, m_doner, m_busy, m_cs_n, m_rd_n, m_wr_n, m_ad_sel, m_ad_oe;
  logic [7:0] m_dataout, m_ad_out;

  always_comb begin
    m_donew   = sel ? donew2   : donew1;
    m_doner   = sel ? doner2   : doner1;
    m_busy    = sel ? busy2    : busy1;
    m_cs_n    = sel ? cs_n2    : cs_n1;
    m_rd_n    = sel ? rd_n2    : rd_n1;
    m_wr_n    = sel ? wr_n2    : wr_n1;
    m_ad_sel  = sel ? ad_sel2  : ad_sel1;
    m_ad_oe   = sel ? ad_oe2   : ad_oe1;
    m_dataout = sel ? dataout2 : dataout1;
    m_ad_out  = sel ? ad_out2  : ad_out1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples on falling edges until a done pulse (bounded), tallying strobe widths and bus-rule violations.
  task automatic run_txn(input logic [7:0] ea, input logic [7:0] ed, input bit is_wr,
                         output int pre, output int lat, output int a_stb, output int d_wr,
                         output int d_rd, output int bad, output int nw, output int nr,
                         output logic [7:0] dout);
    bit started = 1'b0;
    bit done = 1'b0;
    pre = 0; lat = 0; a_stb = 0; d_wr = 0; d_rd = 0; bad = 0; nw = 0; nr = 0; dout = 'x;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clock);
      if (!m_busy) begin
        if (started) bad++;
        else pre++;
      end else begin
        started = 1'b1;
        lat++;
        if (!m_cs_n && !m_ad_sel) begin
          if (m_ad_oe !== 1'b1 || m_ad_out !== ea) bad++;
          if (!m_rd_n) bad++;
          if (!m_wr_n) a_stb++;
        end else if (!m_cs_n) begin
          if (is_wr ? (m_ad_oe !== 1'b1 || m_ad_out !== ed) : (m_ad_oe !== 1'b0)) bad++;
          if (!m_wr_n && !m_rd_n) bad++;
          if (!m_wr_n) d_wr++;
          if (!m_rd_n) d_rd++;
        end else begin
          if (!(m_donew || m_doner) || m_ad_oe !== 1'b0 || !m_rd_n || !m_wr_n) bad++;
        end
        if (m_donew) nw++;
        if (m_doner) nr++;
        if (m_donew || m_doner) begin
          done = 1'b1;
          dout = m_dataout;
        end
      end
    end
    if (!done) lat = -1;
  endtask

  int pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, cnt;
  logic [7:0] dout;
  bit found;

  initial begin
    reset = 1'b1;
    win1 = 0; rin1 = 0; win2 = 0; rin2 = 0;
    address = '0; datain = '0; rd_val = '0;
    repeat (3) @(negedge clock);
    chk("reset_state", {cs_n1, rd_n1, wr_n1, ad_sel1, ad_oe1, ad_out1, donew1, doner1, dataout1, busy1},
        {4'b1111, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0});
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", {busy1, cs_n1, ad_oe1}, 3'b010);

    // 1: write 0x10 to register 0x02
    win1 = 1; address = 8'h02; datain = 8'h10;
    run_txn(8'h02, 8'h10, 1'b1, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    win1 = 0;
    chk("t1_latency", lat, 25);
    chk("t1_addr_strobe", a_stb, 8);
    chk("t1_data_wr", d_wr, 8);
    chk("t1_data_rd", d_rd, 0);
    chk("t1_bus_rules", bad, 0);
    chk("t1_done", {nw[7:0], nr[7:0]}, 16'h0100);
    @(negedge clock);
    chk("t1_single_pulse", {donew1, doner1, busy1}, 3'b000);

    // 2: read 0x45 from register 0x21, then confirm a write leaves dataout alone
    rin1 = 1; address = 8'h21; datain = 8'hAA; rd_val = 8'h45;
    run_txn(8'h21, 8'h00, 1'b0, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    rin1 = 0;
    chk("t2_latency", lat, 25);
    chk("t2_addr_strobe", a_stb, 8);
    chk("t2_rd_width", d_rd, 8);
    chk("t2_no_data_wr", d_wr, 0);
    chk("t2_bus_rules", bad, 0);
    chk("t2_done", {nw[7:0], nr[7:0]}, 16'h0001);
    chk("t2_dataout", dout, 8'h45);
    rd_val = 8'h99;
    win1 = 1; address = 8'h30; datain = 8'h55;
    run_txn(8'h30, 8'h55, 1'b1, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    win1 = 0;
    chk("t2_write_after", {nw[7:0], bad[7:0]}, 16'h0100);
    chk("t2_dataout_held", dout, 8'h45);

    // 3: win held, address advanced on each done
    @(negedge clock);
    win1 = 1; address = 8'h20; datain = 8'h77;
    for (int k = 0; k < 3; k++) begin
      run_txn(8'(8'h20 + k), 8'h77, 1'b1, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
      address = 8'(8'h21 + k);
      if (k == 2) win1 = 0;
      chk($sformatf("t3_gap_%0d", k), pre, (k == 0) ? 0 : 1);
      chk($sformatf("t3_latency_%0d", k), lat, 25);
      chk($sformatf("t3_bus_rules_%0d", k), bad, 0);
      chk($sformatf("t3_donew_%0d", k), nw, 1);
    end
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy1 || donew1) cnt++;
    end
    chk("t3_no_extra", cnt, 0);

    // 4: simultaneous win and rin -> write wins
    win1 = 1; rin1 = 1; address = 8'h05; datain = 8'h99;
    run_txn(8'h05, 8'h99, 1'b1, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    win1 = 0; rin1 = 0;
    chk("t4_done", {nw[7:0], nr[7:0]}, 16'h0100);
    chk("t4_strobes", {d_wr[7:0], d_rd[7:0], bad[7:0]}, 24'h080000);

    // 5: reset mid data strobe
    @(negedge clock);
    win1 = 1; address = 8'h40; datain = 8'h12;
    found = 0;
    for (int g = 0; g < 60 && !found; g++) begin
      @(negedge clock);
      if (!wr_n1 && ad_sel1) found = 1;
    end
    chk("t5_reached_dstb", found, 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1; win1 = 0;
    #1 chk("t5_async_release", {cs_n1, wr_n1, rd_n1, ad_oe1, busy1}, 5'b11100);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (donew1 || doner1 || busy1) cnt++;
    end
    chk("t5_no_done", cnt, 0);
    chk("t5_dataout_cleared", dataout1, 8'h00);
    rin1 = 1; address = 8'h41; rd_val = 8'h3C;
    run_txn(8'h41, 8'h00, 1'b0, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    rin1 = 0;
    chk("t5_recover_latency", lat, 25);
    chk("t5_recover_data", {nr[7:0], bad[7:0], dout}, 24'h01003C);

    // 6: minimum-timing instance, read 0x43
    @(negedge clock);
    sel = 1'b1;
    rin2 = 1; address = 8'h43; rd_val = 8'h5A;
    run_txn(8'h43, 8'h00, 1'b0, pre, lat, a_stb, d_wr, d_rd, bad, nw, nr, dout);
    rin2 = 0;
    chk("t6_latency", lat, 7);
    chk("t6_strobe_widths", {a_stb[7:0], d_rd[7:0], d_wr[7:0]}, 24'h010100);
    chk("t6_bus_rules", bad, 0);
    chk("t6_done", {nw[7:0], nr[7:0]}, 16'h0001);
    chk("t6_dataout", dout, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
